// File: rtl/shifter_pkg.sv
// Shared definitions for the operand-2 shifter sequencer: op and state encodings,
// datapath width and effective-count clamps.
package shifter_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [2:0] {
    SH_LSL     = 3'd0,
    SH_LSR     = 3'd1,
    SH_ASR     = 3'd2,
    SH_ROR     = 3'd3,
    SH_RRX     = 3'd4,
    SH_ROT_IMM = 3'd5
  } sh_op_e;

  typedef enum logic [1:0] {
    SQ_IDLE  = 2'd0,
    SQ_SHIFT = 2'd1,
    SQ_DONE  = 2'd2
  } sq_state_e;

  // Beyond these counts the result and carry no longer change.
  localparam logic [5:0] CNT_MAX_LS  = 6'd33;
  localparam logic [5:0] CNT_MAX_ASR = 6'd32;

  // Codes 110/111 behave as LSL.
  function automatic sh_op_e decode_op(input logic [2:0] code);
    return (code > 3'd5) ? SH_LSL : sh_op_e'(code);
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational shifter slice: advances work/carry by 1..4 bit positions for
// the selected op; the carry is the last bit shifted out.
module shift_step
  import shifter_pkg::*;
(
  input  logic [WIDTH-1:0] work_i,
  input  logic             c_i,
  input  sh_op_e           op_i,
  input  logic [2:0]       step_i,
  output logic [WIDTH-1:0] work_o,
  output logic             c_o
);

  logic [WIDTH-1:0] w;
  logic             c;

  always_comb begin
    w = work_i;
    c = c_i;
    for (int i = 0; i < 4; i++) begin
      if (step_i > 3'(i)) begin
        case (op_i)
          SH_LSR: begin
            c = w[0];
            w = {1'b0, w[WIDTH-1:1]};
          end
          // Bit 31 still holds the captured sign, so replicating it is exact.
          SH_ASR: begin
            c = w[0];
            w = {w[WIDTH-1], w[WIDTH-1:1]};
          end
          SH_ROR, SH_ROT_IMM: begin
            c = w[0];
            w = {w[0], w[WIDTH-1:1]};
          end
          default: begin
            c = w[WIDTH-1];
            w = {w[WIDTH-2:0], 1'b0};
          end
        endcase
      end
    end
    work_o = w;
    c_o    = c;
  end

endmodule

// File: rtl/shifter_sequencer.sv
// Multi-cycle ARM operand-2 shifter sequencer with request/response handshakes.
// SHIFTER_STEP4_EN: process up to 4 bit positions per SHIFT cycle instead of 1.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   SQ_IDLE  | ready for a request; effective count computed on accept
//   SQ_SHIFT | shifting work/carry, remaining count counts down to 0
//   SQ_DONE  | result registered, rsp_valid held until consumer accepts
module shifter_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_operand,
  input  logic [7:0]       req_amount,
  input  logic             req_carry_in,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             busy,
  input  logic             flush
);

  import shifter_pkg::*;

`ifdef SHIFTER_STEP4_EN
  localparam logic [5:0] STEP = 6'd4;
`else
  localparam logic [5:0] STEP = 6'd1;
`endif

  sq_state_e        state_q, state_d;
  sh_op_e           op_q, op_d, op_in;
  logic [WIDTH-1:0] work_q, work_d;
  logic             c_q, c_d;
  logic [5:0]       cnt_q, cnt_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_carry_q, rsp_carry_d;

  logic [WIDTH-1:0] ld_work;
  logic             ld_c;
  logic [5:0]       ld_cnt;
  logic [2:0]       step;
  logic [5:0]       cnt_rem;
  logic [WIDTH-1:0] step_work;
  logic             step_c;
  logic             accept;

  assign op_in     = decode_op(req_op);
  assign req_ready = (state_q == SQ_IDLE) && !reset;
  assign busy      = (state_q != SQ_IDLE);
  assign accept    = req_valid && req_ready && !flush;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_carry  = rsp_carry_q;

  // Load values and effective count for an incoming request.
  always_comb begin
    ld_work = req_operand;
    ld_c    = req_carry_in;
    ld_cnt  = '0;
    case (op_in)
      SH_LSL, SH_LSR: ld_cnt = (req_amount > 8'd33) ? CNT_MAX_LS : req_amount[5:0];
      SH_ASR:         ld_cnt = (req_amount > 8'd32) ? CNT_MAX_ASR : req_amount[5:0];
      SH_ROR: begin
        ld_cnt = {1'b0, req_amount[4:0]};
        if ((req_amount != 8'd0) && (req_amount[4:0] == 5'd0)) ld_c = req_operand[WIDTH-1];
      end
      SH_RRX: begin
        ld_work = {req_carry_in, req_operand[WIDTH-1:1]};
        ld_c    = req_operand[0];
      end
      SH_ROT_IMM: begin
        ld_work = {{(WIDTH-8){1'b0}}, req_operand[7:0]};
        ld_cnt  = {1'b0, req_amount[3:0], 1'b0};
      end
      default: ;
    endcase
  end

  assign step    = (cnt_q > STEP) ? STEP[2:0] : cnt_q[2:0];
  assign cnt_rem = cnt_q - {3'b000, step};

  shift_step u_shift_step (
    .work_i (work_q),
    .c_i    (c_q),
    .op_i   (op_q),
    .step_i (step),
    .work_o (step_work),
    .c_o    (step_c)
  );

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    work_d       = work_q;
    c_d          = c_q;
    cnt_d        = cnt_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_carry_d  = rsp_carry_q;
    case (state_q)
      SQ_IDLE: begin
        if (accept) begin
          op_d    = op_in;
          work_d  = ld_work;
          c_d     = ld_c;
          cnt_d   = ld_cnt;
          state_d = (ld_cnt == 6'd0) ? SQ_DONE : SQ_SHIFT;
        end
      end
      SQ_SHIFT: begin
        work_d = step_work;
        c_d    = step_c;
        cnt_d  = cnt_rem;
        if (cnt_rem == 6'd0) state_d = SQ_DONE;
      end
      SQ_DONE: begin
        // First DONE cycle registers the response; it then holds until taken.
        if (!rsp_valid_q) begin
          rsp_valid_d  = 1'b1;
          rsp_result_d = work_q;
          rsp_carry_d  = c_q;
        end else if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = SQ_IDLE;
        end
      end
      default: state_d = SQ_IDLE;
    endcase
    if (flush) begin
      state_d     = SQ_IDLE;
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= SQ_IDLE;
      op_q         <= SH_LSL;
      work_q       <= '0;
      c_q          <= 1'b0;
      cnt_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      work_q       <= work_d;
      c_q          <= c_d;
      cnt_q        <= cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_carry_q  <= rsp_carry_d;
    end
  end

endmodule

// File: tb/tb_shifter_sequencer.sv
// Directed + random bench for shifter_sequencer: expected responses are queued on
// acceptance and compared (value, carry, latency) when rsp_valid appears.
module tb_shifter_sequencer;

`ifdef SHIFTER_STEP4_EN
  localparam int STEP = 4;
`else
  localparam int STEP = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_operand = 32'd0;
  logic [7:0]  req_amount = 8'd0;
  logic        req_carry_in = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic        rsp_carry;
  logic        busy;
  logic        flush = 1'b0;

  always #5 clk = ~clk;

  shifter_sequencer #(.WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_operand  (req_operand),
    .req_amount   (req_amount),
    .req_carry_in (req_carry_in),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_carry    (rsp_carry),
    .busy         (busy),
    .flush        (flush)
  );

  typedef struct {
    logic [31:0] res;
    logic        c;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // ARM operand-2 shifter reference, written from the architectural definition.
  function automatic logic [32:0] model(input logic [2:0] op, input logic [31:0] v,
                                        input logic [7:0] a, input logic cin);
    logic [31:0] r;
    logic        c;
    int          n;
    r = v;
    c = cin;
    n = int'(a);
    case (op)
      3'd1: if (n != 0) begin
        if (n < 32) begin r = v >> n; c = v[n-1]; end
        else if (n == 32) begin r = 32'd0; c = v[31]; end
        else begin r = 32'd0; c = 1'b0; end
      end
      3'd2: if (n != 0) begin
        if (n < 32) begin r = 32'($signed(v) >>> n); c = v[n-1]; end
        else begin r = {32{v[31]}}; c = v[31]; end
      end
      3'd3: if (n != 0) begin
        n = int'(a[4:0]);
        if (n == 0) c = v[31];
        else begin r = (v >> n) | (v << (32 - n)); c = r[31]; end
      end
      3'd4: begin r = {cin, v[31:1]}; c = v[0]; end
      3'd5: begin
        r = {24'd0, v[7:0]};
        n = 2 * int'(a[3:0]);
        if (n != 0) begin r = (r >> n) | (r << (32 - n)); c = r[31]; end
      end
      default: if (n != 0) begin
        if (n < 32) begin r = v << n; c = v[32-n]; end
        else if (n == 32) begin r = 32'd0; c = v[0]; end
        else begin r = 32'd0; c = 1'b0; end
      end
    endcase
    return {c, r};
  endfunction

  function automatic int exp_lat(input logic [2:0] op, input logic [7:0] a);
    int cnt;
    case (op)
      3'd2:    cnt = (a > 8'd32) ? 32 : int'(a);
      3'd3:    cnt = int'(a[4:0]);
      3'd4:    cnt = 0;
      3'd5:    cnt = 2 * int'(a[3:0]);
      default: cnt = (a > 8'd33) ? 33 : int'(a);
    endcase
    return (cnt == 0) ? 1 : (cnt + STEP - 1) / STEP + 1;
  endfunction

  // Present a request, wait for acceptance, push the expected response.
  task automatic send(input logic [2:0] op, input logic [31:0] v, input logic [7:0] a,
                      input logic cin, input logic [31:0] er, input logic ec);
    int   k;
    exp_t e;
    k = 0;
    req_op = op; req_operand = v; req_amount = a; req_carry_in = cin; req_valid = 1'b1;
    while (!req_ready && k < 50) begin @(posedge clk); #1; k++; end
    check("req_ready_wait", 32'(k < 50), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    e.res = er; e.c = ec; e.lat = exp_lat(op, a);
    sb.push_back(e);
  endtask

  task automatic send_m(input logic [2:0] op, input logic [31:0] v, input logic [7:0] a,
                        input logic cin);
    logic [32:0] m;
    m = model(op, v, a, cin);
    send(op, v, a, cin, m[31:0], m[32]);
  endtask

  // Wait for the response, compare, optionally hold off rsp_ready, then complete it.
  task automatic collect(input string tag, input int hold);
    exp_t        e;
    int          k;
    logic [31:0] r0;
    logic        c0;
    k = 0;
    e = sb.pop_front();
    while (!rsp_valid && k < 100) begin @(posedge clk); #1; k++; end
    check({tag, "_latency"}, 32'(k), 32'(e.lat));
    check({tag, "_result"}, rsp_result, e.res);
    check({tag, "_carry"}, {31'd0, rsp_carry}, {31'd0, e.c});
    r0 = rsp_result;
    c0 = rsp_carry;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_result"}, rsp_result, r0);
      check({tag, "_hold_flags"}, {28'd0, rsp_carry, rsp_valid, busy, req_ready},
            {28'd0, c0, 1'b1, 1'b1, 1'b0});
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({tag, "_after_hs"}, {29'd0, rsp_valid, busy, req_ready}, {29'd0, 1'b0, 1'b0, 1'b1});
  endtask

  task automatic watch_quiet(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (rsp_valid || busy) seen++;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]  a;
    logic [2:0]  op;
    exp_t        dropped;

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {rsp_result[30:0], rsp_carry, rsp_valid, busy, req_ready} , 34'd0 >> 0);
    check("reset_result", rsp_result, 32'd0);
    reset = 1'b0;
    #1;
    check("ready_after_reset", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;

    send(3'd0, 32'h0000_00F1, 8'd4, 1'b0, 32'h0000_0F10, 1'b0);   collect("lsl4", 0);
    send(3'd2, 32'h8000_0000, 8'd40, 1'b0, 32'hFFFF_FFFF, 1'b1);  collect("asr40", 0);
    send(3'd1, 32'h8000_0001, 8'd32, 1'b0, 32'h0000_0000, 1'b1);  collect("lsr32", 0);
    send(3'd3, 32'h0000_0003, 8'h20, 1'b0, 32'h0000_0003, 1'b0);  collect("ror32", 0);
    send(3'd4, 32'h0000_0001, 8'd0, 1'b1, 32'h8000_0000, 1'b1);   collect("rrx", 0);
    send(3'd5, 32'h0000_00FF, 8'h4, 1'b0, 32'hFF00_0000, 1'b1);   collect("rotimm8", 0);
    send(3'd5, 32'h0000_00FF, 8'h0, 1'b0, 32'h0000_00FF, 1'b0);   collect("rotimm0", 0);
    send(3'd0, 32'h0000_0001, 8'd32, 1'b0, 32'h0000_0000, 1'b1);  collect("lsl32", 0);
    send(3'd0, 32'hFFFF_FFFF, 8'd33, 1'b1, 32'h0000_0000, 1'b0);  collect("lsl33", 0);
    send(3'd1, 32'hFFFF_FFFF, 8'd200, 1'b1, 32'h0000_0000, 1'b0); collect("lsr200", 0);
    send(3'd0, 32'h0000_1234, 8'd0, 1'b1, 32'h0000_1234, 1'b1);   collect("lsl0", 0);
    send(3'd6, 32'h0000_0003, 8'd3, 1'b1, 32'h0000_0018, 1'b0);   collect("op110", 0);
    send(3'd2, 32'h4000_0010, 8'd5, 1'b0, 32'h0200_0000, 1'b1);   collect("asr5", 0);

    send(3'd0, 32'h0000_1234, 8'd3, 1'b0, 32'h0000_91A0, 1'b0);   collect("backpressure", 5);

    // Flush mid-shift, with a competing request on the same cycle.
    send_m(3'd0, 32'h0000_0001, 8'd20, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    flush = 1'b1; req_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    dropped = sb.pop_back();
    check("flush_idle", {30'd0, busy, rsp_valid}, 32'd0);
    watch_quiet("flush_no_rsp", 30);
    flush = 1'b1; req_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    check("flush_beats_req", {30'd0, busy, req_ready}, 32'd1);
    send(3'd0, 32'h0000_0001, 8'd1, 1'b0, 32'h0000_0002, 1'b0);   collect("post_flush", 0);

    // Reset mid-shift.
    send_m(3'd0, 32'h0000_0001, 8'd20, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("reset_ready_low", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    check("reset_mid_flags", {29'd0, busy, rsp_valid, rsp_carry}, 32'd0);
    check("reset_mid_result", rsp_result, 32'd0);
    reset = 1'b0;
    dropped = sb.pop_back();
    #1;
    check("reset_ready_high", {31'd0, req_ready}, 32'd1);
    watch_quiet("reset_no_rsp", 30);
    send(3'd0, 32'h0000_0001, 8'd1, 1'b0, 32'h0000_0002, 1'b0);   collect("post_reset", 0);

    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = (i % 3 == 0) ? 8'($urandom) : 8'($urandom_range(0, 40));
      send_m(op, $urandom, a, 1'($urandom));
      collect("random", 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/shifter_sequencer.md
# shifter_sequencer

Multi-cycle sequencer for the operand-2 shifter in the pipelined ARM-subset datapath. It accepts one shift request at a time and shifts bit-serially, or by up to 4 bits with the configuration option. It produces the ARM shifter result and the carry-out. `busy` stalls the ID/EX pipeline while a shift is in flight.

## Interface
- `WIDTH`, 32: operand/result width; only 32 is supported.
- `clk  in  1`: single clock; all state changes on the rising edge.
- `reset  in  1`: synchronous, active-high.
- `req_valid  in  1`: request present.
- `req_ready  out  1`: high only in IDLE with `reset` low.
- `req_op  in  3`: 000 LSL, 001 LSR, 010 ASR, 011 ROR, 100 RRX, 101 ROT_IMM. Codes 110/111 are treated as LSL.
- `req_operand  in  32`: value to shift. ROT_IMM uses `[7:0]` zero-extended.
- `req_amount  in  8`: shift amount (Rs[7:0] or imm5). ROT_IMM uses `[3:0]` ×2.
- `req_carry_in  in  1`: current CPSR C.
- `rsp_valid  out  1`: result available.
- `rsp_ready  in  1`: consumer accepts the result.
- `rsp_result  out  32`: shifted value.
- `rsp_carry  out  1`: shifter carry-out.
- `busy  out  1`: high in SHIFT or DONE; the pipeline stalls on it.
- `flush  in  1`: synchronous abort.

## Operation
- States:
  - IDLE → SHIFT on `req_valid && req_ready` when the effective count `cnt` > 0.
  - IDLE → DONE when `cnt` = 0.
  - SHIFT → DONE when the remaining count reaches 0.
  - DONE → IDLE on `rsp_valid && rsp_ready`.
- On acceptance, capture `work = operand` (ROT_IMM: `{24'b0, operand[7:0]}`) and `c = req_carry_in`. Compute `cnt` as follows:
  - LSL/LSR: `min(amount, 33)`.
  - ASR: `min(amount, 32)`.
  - ROR: `amount[4:0]`. If `amount != 0` and `amount[4:0] == 0`, then `cnt = 0` and `c = operand[31]` (result unchanged).
  - RRX: load `work = {carry_in, operand[31:1]}`, `c = operand[0]`, `cnt = 0`.
  - ROT_IMM: `cnt = 2*amount[3:0]`. In DONE, if `cnt != 0`, `rsp_carry = work[31]`.
- Each SHIFT cycle processes `step = min(remaining, STEP)` bit positions (STEP = 1, or 4 with the macro). `c` takes the last bit shifted out, so 33 shifts give C = 0.
  - LSL: shifts in 0.
  - LSR: shifts in 0.
  - ASR: shifts in the captured `operand[31]`.
  - ROR and ROT_IMM: bit 0 rotates into bit 31.
- Resulting ARM boundaries:
  - LSL #32: 0, C = op[0].
  - LSL >32: 0, C = 0.
  - LSR #32: 0, C = op[31].
  - ASR ≥32: all sign bits, C = sign.
  - Amount 0 (any op except RRX): result = operand, C = carry_in.
- `rsp_result`/`rsp_carry` are registered. They are valid and stable whenever `rsp_valid` = 1 and hold until the handshake completes.
- `flush` = 1: next state IDLE from any state, `rsp_valid` → 0, any pending result is discarded. `flush` beats a same-cycle request: no accept.
- `reset` = 1, in any state including mid-shift: state IDLE, `rsp_valid` 0, `rsp_result` 0, `rsp_carry` 0, `busy` 0, `req_ready` 0 during the reset cycle and 1 afterwards.

## Timing
- Acceptance at edge T. `rsp_valid` rises at edge T + ceil(`cnt`/STEP) + 1.
  - `cnt` = 0: T+1.
  - LSL #5 with STEP 1: T+6.
- `req_ready` is low from T+1 until the edge after the response handshake. There is no back-to-back acceptance in the DONE-exit cycle; the next request can be accepted one cycle later.
- `busy` equals `state != IDLE`, registered-state decode with no combinational path from `req_valid`.
- Worst case: LSL/LSR by 33 with STEP 1 gives 34 cycles to `rsp_valid`.

## Configuration
- `SHIFTER_STEP4_EN` defined: STEP = 4, so up to 4 positions per cycle. The final partial step shifts the remainder, and carry is the last bit out of that step.
- Not defined: STEP = 1.
- Results and carries are identical either way; only latency differs.

## Structure
- Shared package `shifter_pkg`: `req_op` encodings (`SH_LSL` … `SH_ROT_IMM`), state encodings (`SQ_IDLE`, `SQ_SHIFT`, `SQ_DONE`), `WIDTH` constant, count clamp constants (33, 32).
- One sub-module, `shift_step`: combinational; inputs are `work`, `c`, op, step count (1–4). It returns the next `work` and next `c`. It is instantiated once. The FSM, counter and handshake stay in `shifter_sequencer`.

## Test plan
- LSL operand 0x0000_00F1, amount 4, cin 0 → result 0x0000_0F10, C = 0; `rsp_valid` at T+5 (STEP 1) / T+2 (STEP 4).
- ASR operand 0x8000_0000, amount 40 → result 0xFFFF_FFFF, C = 1. LSR operand 0x8000_0001, amount 32 → result 0, C = 1.
- ROR operand 0x0000_0003, amount 0x20 → result 0x0000_0003, C = 0, at T+1. RRX operand 0x0000_0001, cin 1 → result 0x8000_0000, C = 1.
- ROT_IMM operand 0xFF, amount 0x4 (rotate 8) → result 0xFF00_0000, C = 1. Amount 0, cin 0 → result 0xFF, C = 0.
- Backpressure: hold `rsp_ready` 0 for 5 cycles after `rsp_valid` → result/carry stable, `busy` = 1, `req_ready` = 0. `rsp_ready` 1 → IDLE next cycle.
- `flush` or `reset` asserted mid-SHIFT of LSL #20 → IDLE next edge, no `rsp_valid`. A subsequent LSL 0x1 #1 returns 0x2, C = 0.
